mod_reducer: RTL and testbench
==============================

Name: mod_reducer

Overview:
Parametrised, handshaked modulo unit computing numerator mod denominator for the Mersenne trial-factoring datapath. It succeeds the fixed-width shift-and-subtract modulo block. New features: independent numerator and denominator widths, leading-zero skip, valid/ready handshakes with output backpressure, divide-by-zero flagging, and abort. Results feed the modular-exponentiation sequencer.

Parameters:
NUM_WIDTH, 64, numerator width in bits (≥2)
DEN_WIDTH, 32, denominator and remainder width in bits (2 ≤ DEN_WIDTH ≤ NUM_WIDTH)

Ports:
sys_clk  in  1  clock; all state updates on rising edge
sys_rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous cancel of the operation in flight
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
numerator  in  NUM_WIDTH  dividend
denominator  in  DEN_WIDTH  modulus
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
remainder  out  DEN_WIDTH  numerator mod denominator
div_by_zero  out  1  result produced with denominator == 0
busy  out  1  state != IDLE

Behaviour:
- Reset: async assert forces state=IDLE, out_valid=0, remainder=0, div_by_zero=0, busy=0, count=0. in_ready=1 after reset deasserts. Reset mid-operation discards the operation with no output.
- in_ready = (state==IDLE). Operands are accepted on an edge with in_valid&in_ready. They are latched into internal registers, and input pins are don't-care afterwards.
- States are IDLE, SCAN, DIVIDE, DONE.
- IDLE, on accept with denominator==0: go to DONE, remainder=numerator[DEN_WIDTH-1:0], div_by_zero=1.
- IDLE, on accept with denominator≠0: go to SCAN, div_by_zero=0, working remainder=0.
- SCAN (1 cycle): a priority encoder finds msb, the index of the highest set numerator bit.
  - If numerator==0: go to DONE with remainder=0.
  - Otherwise: count=msb, go to DIVIDE.
- DIVIDE processes one bit per cycle:
  - t = {r, numerator[count]}, held in a DEN_WIDTH+1-bit intermediate. No truncation is allowed before the compare.
  - r <= (t ≥ denominator) ? t−denominator : t. The result always fits in DEN_WIDTH bits.
  - When count==0, go to DONE; otherwise decrement count.
  - count width is $clog2(NUM_WIDTH). It never wraps, because it is never decremented from 0.
- DONE: out_valid=1.
  - remainder and div_by_zero are held stable until out_valid&out_ready. Then go to IDLE and deassert out_valid on that edge.
  - in_ready rises the following cycle; there is no same-cycle result/accept turnaround.
- Latency, counted in cycles from the accept edge to the first cycle with out_valid high:
  - div-by-zero: 1
  - numerator==0: 2
  - otherwise: msb+3 (1 SCAN + msb+1 DIVIDE + 1)
  - Worst case is NUM_WIDTH+2.
- abort:
  - In SCAN, DIVIDE or DONE: go to IDLE next edge, out_valid=0, result dropped.
  - In IDLE: ignored, and it blocks acceptance that cycle (abort has priority over in_valid).
  - Simultaneous abort and out_ready in DONE: treated as abort; the result counts as not consumed.
- remainder port: holds the last result while IDLE. Intermediate values need not be hidden, but consumers sample only when out_valid=1.
- busy = state≠IDLE.

Test Plan:
1. Defaults, numerator=100, denominator=7 → out_valid 9 cycles after accept, remainder=2, div_by_zero=0; in_ready low throughout, high the cycle after the out handshake.
2. numerator=0xFFFF_FFFF_FFFF_FFFF, denominator=0xFFFF_FFFE → remainder=3 after 66 cycles (exercises the 33-bit intermediate). Then numerator=0xFFFF_FFFF_FFFF_FFFF, denominator=0xFFFF_FFFF → remainder=0.
3. numerator=5, denominator=9 → remainder=5. numerator=0, denominator=9 → remainder=0 at latency 2. numerator=0x1_0000_1234, denominator=0 → remainder=0x0000_1234, div_by_zero=1, latency 1.
4. Backpressure: out_ready held low 20 cycles after out_valid → remainder and out_valid stable, in_valid ignored. Then out_ready pulse → out_valid drops next edge.
5. abort asserted mid-DIVIDE (cycle 10 of test 2) → IDLE next edge, no out_valid. A follow-up 100 mod 7 returns 2. abort together with out_ready in DONE → out_valid drops, in_ready=1.
6. sys_rst_n pulsed low asynchronously mid-DIVIDE → all outputs take reset values immediately. After release, back-to-back random operands (including denominator=1 and denominator=2^32−1) match a reference model, including NUM_WIDTH=128/DEN_WIDTH=64 and NUM_WIDTH=DEN_WIDTH=16 builds.

Source files
------------

// File: rtl/mod_reducer_if.sv
//------------------------------------------------------------------------------
// Module   : mod_reducer_if
// Function : Operand/result valid-ready bundle for the mod_reducer unit.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mod_reducer_if #(
    parameter int NUM_WIDTH = 64,
    parameter int DEN_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_WIDTH-1:0] numerator;
    logic [DEN_WIDTH-1:0] denominator;
    logic                 out_valid;
    logic                 out_ready;
    logic [DEN_WIDTH-1:0] remainder;
    logic                 div_by_zero;

    modport master (
        output in_valid, numerator, denominator, out_ready,
        input  in_ready, out_valid, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, numerator, denominator, out_ready,
        output in_ready, out_valid, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/mod_reducer.sv
//------------------------------------------------------------------------------
// Module   : mod_reducer
// Function : Handshaked bit-serial numerator mod denominator with leading-zero skip.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_reducer #(
    parameter int NUM_WIDTH = 64,
    parameter int DEN_WIDTH = 32
) (
    input  wire logic       sys_clk,
    input  wire logic       sys_rst_n,
    input  wire logic       abort,
    output logic            busy,
    mod_reducer_if.slave    bus
);
    localparam int CW = (NUM_WIDTH > 1) ? $clog2(NUM_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_DIVIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [NUM_WIDTH-1:0] r_num;
    logic [DEN_WIDTH-1:0] r_den;
    logic [DEN_WIDTH-1:0] r_rem;
    logic [CW-1:0]        r_count;
    logic                 r_out_valid;
    logic                 r_dbz;

    logic [CW-1:0]        w_msb;
    logic [DEN_WIDTH:0]   w_t;
    logic [DEN_WIDTH:0]   w_diff;
    logic                 w_ge;

    // Highest set bit of the latched numerator; later indices override earlier ones.
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < NUM_WIDTH; i++) begin
            if (r_num[i]) begin
                w_msb = CW'(i);
            end
        end
    end

    // One extra bit keeps the shifted remainder exact before the compare.
    assign w_t    = {r_rem, r_num[r_count]};
    assign w_diff = w_t - {1'b0, r_den};
    assign w_ge   = (w_t >= {1'b0, r_den});

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_den       <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
        end else if (abort) begin
            if (r_state != S_IDLE) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_num <= bus.numerator;
                        r_den <= bus.denominator;
                        if (bus.denominator == '0) begin
                            r_state     <= S_DONE;
                            r_rem       <= bus.numerator[DEN_WIDTH-1:0];
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                            r_rem   <= '0;
                            r_dbz   <= 1'b0;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_num == '0) begin
                        r_state     <= S_DONE;
                        r_rem       <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_count <= w_msb;
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_ge ? w_diff[DEN_WIDTH-1:0] : w_t[DEN_WIDTH-1:0];
                    if (r_count == '0) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
    assign busy            = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mod_reducer.sv
//------------------------------------------------------------------------------
// Module   : tb_mod_reducer
// Function : Self-checking bench for mod_reducer (default 64/32 build).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_reducer;
    localparam int NW = 64;
    localparam int DW = 32;

    logic sys_clk;
    logic sys_rst_n;
    logic abort;
    logic busy;

    mod_reducer_if #(.NUM_WIDTH(NW), .DEN_WIDTH(DW)) bus ();

    mod_reducer #(.NUM_WIDTH(NW), .DEN_WIDTH(DW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .abort     (abort),
        .busy      (busy),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [NW-1:0] num;
        logic [DW-1:0] den;
        logic [DW-1:0] rem;
        bit            dbz;
        int            lat;
        int            hold;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rem;
        bit            dbz;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t ref_model(input logic [NW-1:0] n, input logic [DW-1:0] d);
        exp_t e;
        int   msb;
        msb = 0;
        if (d == '0) begin
            e.rem = n[DW-1:0];
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.rem = DW'(n % {{(NW-DW){1'b0}}, d});
            e.dbz = 1'b0;
            for (int i = 0; i < NW; i++) if (n[i]) msb = i;
            e.lat = (n == '0) ? 2 : msb + 3;
        end
        return e;
    endfunction

    // Issue one operation, push its expectation, wait for the result, consume it.
    task automatic do_op(input string name, input logic [NW-1:0] n, input logic [DW-1:0] d,
                         input exp_t e, input int hold);
        int   cyc;
        int   lat;
        bit   rdy_low;
        bit   stable;
        exp_t got;
        cyc = 0;
        while (!bus.in_ready && cyc < 200) begin
            @(negedge sys_clk);
            cyc++;
        end
        chk({name, "_in_ready_before"}, 64'(bus.in_ready), 64'd1);
        bus.numerator   = n;
        bus.denominator = d;
        bus.in_valid    = 1'b1;
        sb.push_back(e);
        @(posedge sys_clk);
        @(negedge sys_clk);
        bus.in_valid    = 1'b0;
        bus.numerator   = {32'($urandom), 32'($urandom)};
        bus.denominator = 32'($urandom);
        lat     = 1;
        rdy_low = 1'b1;
        while (!bus.out_valid && lat < 300) begin
            if (bus.in_ready || !busy) rdy_low = 1'b0;
            @(negedge sys_clk);
            lat++;
        end
        got = sb.pop_front();
        if (!bus.out_valid) begin
            chk({name, "_timeout"}, 64'(bus.out_valid), 64'd1);
            return;
        end
        chk({name, "_rem"}, 64'(bus.remainder), 64'(got.rem));
        chk({name, "_dbz"}, 64'(bus.div_by_zero), 64'(got.dbz));
        chk({name, "_lat"}, 64'(lat), 64'(got.lat));
        chk({name, "_in_ready_low"}, 64'(rdy_low), 64'd1);
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = 1'b1;
                @(negedge sys_clk);
                if (!bus.out_valid || bus.in_ready || bus.remainder !== got.rem ||
                    bus.div_by_zero !== got.dbz) stable = 1'b0;
            end
            bus.in_valid = 1'b0;
            chk({name, "_hold_stable"}, 64'(stable), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        bus.out_ready = 1'b0;
        chk({name, "_post_hs"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    endtask

    vec_t vecs[7];
    exp_t e;
    logic [NW-1:0] rn;
    logic [DW-1:0] rd;
    bit   seen;

    initial begin
        vecs[0] = '{64'd100, 32'd7, 32'd2, 1'b0, 9, 20};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFE, 32'd3, 1'b0, 66, 0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 66, 0};
        vecs[3] = '{64'd5, 32'd9, 32'd5, 1'b0, 5, 0};
        vecs[4] = '{64'd0, 32'd9, 32'd0, 1'b0, 2, 0};
        vecs[5] = '{64'h1_0000_1234, 32'd0, 32'h0000_1234, 1'b1, 1, 3};
        vecs[6] = '{64'h1234, 32'd1, 32'd0, 1'b0, 15, 0};

        sys_rst_n       = 1'b0;
        abort           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.numerator   = '0;
        bus.denominator = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("reset_flags", {59'd0, bus.in_ready, bus.out_valid, busy, bus.div_by_zero, 1'b0},
            64'b10000);
        chk("reset_rem", 64'(bus.remainder), 64'd0);

        for (int i = 0; i < 7; i++) begin
            e.rem = vecs[i].rem;
            e.dbz = vecs[i].dbz;
            e.lat = vecs[i].lat;
            do_op($sformatf("vec%0d", i), vecs[i].num, vecs[i].den, e, vecs[i].hold);
        end

        // abort in IDLE blocks acceptance
        bus.numerator = 64'd100; bus.denominator = 32'd7;
        bus.in_valid = 1'b1; abort = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        bus.in_valid = 1'b0; abort = 1'b0;
        chk("abort_idle_block", {63'd0, busy}, 64'd0);

        // abort mid-DIVIDE
        bus.numerator = 64'hFFFF_FFFF_FFFF_FFFF; bus.denominator = 32'hFFFF_FFFE;
        bus.in_valid = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge sys_clk);
        abort = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        abort = 1'b0;
        chk("abort_div", {61'd0, bus.in_ready, busy, bus.out_valid}, 64'b100);
        seen = 1'b0;
        repeat (70) begin
            @(negedge sys_clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_output", 64'(seen), 64'd0);
        do_op("after_abort", 64'd100, 32'd7, ref_model(64'd100, 32'd7), 0);

        // abort together with out_ready in DONE
        bus.numerator = 64'd100; bus.denominator = 32'd7;
        bus.in_valid = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge sys_clk);
        chk("abort_done_valid", 64'(bus.out_valid), 64'd1);
        abort = 1'b1; bus.out_ready = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        abort = 1'b0; bus.out_ready = 1'b0;
        chk("abort_done", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);

        // async reset mid-DIVIDE
        bus.numerator = 64'hFFFF_FFFF_FFFF_FFFF; bus.denominator = 32'hFFFF_FFFE;
        bus.in_valid = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge sys_clk);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {60'd0, bus.in_ready, bus.out_valid, busy, bus.div_by_zero},
            64'b1000);
        chk("async_rst_rem", 64'(bus.remainder), 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // back-to-back random operands against the reference model
        for (int i = 0; i < 24; i++) begin
            rn = {32'($urandom), 32'($urandom)};
            rn = rn >> $urandom_range(0, 63);
            rd = 32'($urandom) >> $urandom_range(0, 31);
            if (i == 0) rd = 32'd1;
            if (i == 1) rd = 32'hFFFF_FFFF;
            if (i == 2) rd = 32'd0;
            if (i == 3) rn = '0;
            if (i == 4) rd = 32'd2;
            do_op($sformatf("rand%0d", i), rn, rd, ref_model(rn, rd), (i % 5 == 0) ? 2 : 0);
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
